// File: rtl/alu_pwr_seq.sv
// alu_pwr_seq: power sequencer for the ALU power domain.
// Converts single-cycle sleep/wake requests into an ordered sequence on
// alu_pwr_en / iso_en / save / restore. It also gates the ALU start strobe
// so that no operation is launched outside ACTIVE.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ACTIVE  0  | domain powered, outputs live, starts allowed
// DRAIN   1  | starts blocked, waiting for the in-flight op to finish
// SAVE    2  | one-cycle state-save strobe
// ISO_ON  3  | isolation up, held ISO_SETUP cycles before power drops
// OFF     4  | domain unpowered, isolated
// PWR_ON  5  | power back, isolated, held PWR_UP cycles to settle
// RESTORE 6  | one-cycle state-restore strobe
// ISO_OFF 7  | isolation released, one cycle before ACTIVE
// RSVD    8  | reserved; any illegal encoding falls back to ACTIVE
module alu_pwr_seq #(
  parameter int ISO_SETUP = 2,
  parameter int PWR_UP    = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       start_in,
  input  logic       alu_busy,
  output logic       start_out,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       alu_ready,
  output logic       alu_off,
  output logic [3:0] seq_state
);

  typedef enum logic [3:0] {
    ST_ACTIVE  = 4'd0,
    ST_DRAIN   = 4'd1,
    ST_SAVE    = 4'd2,
    ST_ISO_ON  = 4'd3,
    ST_OFF     = 4'd4,
    ST_PWR_ON  = 4'd5,
    ST_RESTORE = 4'd6,
    ST_ISO_OFF = 4'd7,
    ST_RSVD    = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_UP - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               wake_pend;
  logic               sleep_pend;
  logic               start_d;

  // Starts reach the ALU only while the domain is fully active.
  assign start_out = start_in & (state == ST_ACTIVE);
  assign seq_state = state;

  // Next-state decode; pending flags let a request raised mid-sequence take
  // effect as soon as the opposite sequence has completed.
  always_comb begin
    next_state = state;
    case (state)
      ST_ACTIVE:  if (sleep_req || sleep_pend) next_state = ST_DRAIN;
      ST_DRAIN:   if (!alu_busy && !start_d)   next_state = ST_SAVE;
      ST_SAVE:    next_state = ST_ISO_ON;
      ST_ISO_ON:  if (cnt == ISO_LAST)         next_state = ST_OFF;
      ST_OFF:     if (wake_req || wake_pend)   next_state = ST_PWR_ON;
      ST_PWR_ON:  if (cnt == PWR_LAST)         next_state = ST_RESTORE;
      ST_RESTORE: next_state = ST_ISO_OFF;
      ST_ISO_OFF: next_state = ST_ACTIVE;
      default:    next_state = ST_ACTIVE;
    endcase
  end

  // State, delay counter, pending flags and outputs, all registered from
  // next_state so each output moves on the same edge as its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ACTIVE;
      cnt        <= '0;
      wake_pend  <= 1'b0;
      sleep_pend <= 1'b0;
      start_d    <= 1'b0;
      alu_pwr_en <= 1'b1;
      iso_en     <= 1'b0;
      save       <= 1'b0;
      restore    <= 1'b0;
      alu_ready  <= 1'b1;
      alu_off    <= 1'b0;
    end else begin
      state   <= next_state;
      start_d <= start_out;

      if (next_state != state)
        cnt <= '0;
      else if (state == ST_ISO_ON || state == ST_PWR_ON)
        cnt <= cnt + CNT_W'(1);

      if (state == ST_OFF && next_state == ST_PWR_ON)
        wake_pend <= 1'b0;
      else if (wake_req && (state inside {ST_DRAIN, ST_SAVE, ST_ISO_ON}))
        wake_pend <= 1'b1;

      if (state == ST_ACTIVE && next_state == ST_DRAIN)
        sleep_pend <= 1'b0;
      else if (sleep_req && (state inside {ST_PWR_ON, ST_RESTORE, ST_ISO_OFF}))
        sleep_pend <= 1'b1;

      alu_pwr_en <= (next_state != ST_OFF);
      iso_en     <= (next_state inside {ST_ISO_ON, ST_OFF, ST_PWR_ON, ST_RESTORE});
      save       <= (next_state == ST_SAVE);
      restore    <= (next_state == ST_RESTORE);
      alu_ready  <= (next_state == ST_ACTIVE);
      alu_off    <= (next_state == ST_OFF);
    end
  end

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Testbench for alu_pwr_seq: directed scenarios followed by random requests,
// compared cycle by cycle against a behavioural model of the sequence.
module tb_alu_pwr_seq;
  localparam int ISO_SETUP = 2;
  localparam int PWR_UP    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sleep_req, wake_req, start_in, alu_busy;
  logic       start_out, alu_pwr_en, iso_en, save, restore, alu_ready, alu_off;
  logic [3:0] seq_state;

  always #5 clk = ~clk;

  alu_pwr_seq #(.ISO_SETUP(ISO_SETUP), .PWR_UP(PWR_UP), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sleep_req(sleep_req), .wake_req(wake_req),
    .start_in(start_in), .alu_busy(alu_busy), .start_out(start_out),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .save(save), .restore(restore),
    .alu_ready(alu_ready), .alu_off(alu_off), .seq_state(seq_state)
  );

  int checks = 0;
  int errors = 0;

  // sequence model: phase number, remaining hold cycles, pending flags
  int m_st, m_rem;
  bit m_wp, m_sp, m_sd;
  // ALU model: multi-cycle MUL, state lost when unpowered
  int busy_cnt = 0;
  int product = 0, result = 0, saved = 0;
  int opa = 3, opb = 5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit exp_pwr(int s);
    return s != 4;
  endfunction

  function automatic bit exp_iso(int s);
    return (s >= 3) && (s <= 6);
  endfunction

  task automatic model_reset();
    m_st = 0; m_rem = 0; m_wp = 0; m_sp = 0; m_sd = 0;
  endtask

  task automatic check_outputs();
    chk("seq_state", seq_state, m_st);
    chk("alu_pwr_en", alu_pwr_en, exp_pwr(m_st));
    chk("iso_en", iso_en, exp_iso(m_st));
    chk("save", save, m_st == 2);
    chk("restore", restore, m_st == 6);
    chk("alu_ready", alu_ready, m_st == 0);
    chk("alu_off", alu_off, m_st == 4);
    chk("inv_save_restore", save & restore, 0);
    chk("inv_pwr_iso", (!alu_pwr_en) & (!iso_en), 0);
  endtask

  // one clock: drive inputs, step model and ALU at the edge, check after it
  task automatic cycle(input bit s, input bit w, input bit st);
    bit so_obs;
    bit so_exp;
    sleep_req = s; wake_req = w; start_in = st; alu_busy = (busy_cnt != 0);
    #1;
    so_exp = st && (m_st == 0);
    chk("start_out", start_out, so_exp);
    so_obs = start_out;
    @(posedge clk);
    if (w && m_st >= 1 && m_st <= 3) m_wp = 1;
    if (s && m_st >= 5 && m_st <= 7) m_sp = 1;
    case (m_st)
      0: if (s || m_sp) begin m_st = 1; m_sp = 0; end
      1: if (!alu_busy && !m_sd) m_st = 2;
      2: begin m_st = 3; m_rem = ISO_SETUP; end
      3: begin m_rem--; if (m_rem == 0) m_st = 4; end
      4: if (w || m_wp) begin m_st = 5; m_wp = 0; m_rem = PWR_UP; end
      5: begin m_rem--; if (m_rem == 0) m_st = 6; end
      6: m_st = 7;
      default: m_st = 0;
    endcase
    m_sd = so_exp;
    if (so_obs && busy_cnt == 0) begin
      busy_cnt = 4;
      product = opa * opb;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) result = product;
    end
    #1;
    check_outputs();
    if (save) saved = result;
    if (restore) result = saved;
    if (!alu_pwr_en) result = 0;
  endtask

  task automatic run_until(input int target, input int limit, output int n);
    n = 0;
    while (seq_state !== 4'(target) && n < limit) begin
      cycle(0, 0, 0);
      n++;
    end
    chk($sformatf("reach_state_%0d", target), seq_state, target);
  endtask

  task automatic check_reset_values();
    chk("rst_state", seq_state, 0);
    chk("rst_pwr", alu_pwr_en, 1);
    chk("rst_iso", iso_en, 0);
    chk("rst_save", save, 0);
    chk("rst_restore", restore, 0);
    chk("rst_ready", alu_ready, 1);
    chk("rst_off", alu_off, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rc, oc;
    rst_n = 1'b0; sleep_req = 0; wake_req = 0; start_in = 0; alu_busy = 0;
    model_reset();
    #12;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // idle sleep: latency to alu_off, then wake latency to alu_ready
    cycle(1, 0, 0);
    chk("drain_first", seq_state, 1);
    run_until(4, 20, n);
    chk("sleep_latency", 1 + n, ISO_SETUP + 3);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 1, 0);
    chk("pwr_on_next", alu_pwr_en, 1);
    run_until(0, 20, n);
    chk("wake_latency", 1 + n, PWR_UP + 3);

    // MUL in flight when sleep arrives: save waits for the result
    opa = 3; opb = 5;
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    cycle(0, 0, 1);
    chk("start_gated_drain", start_out, 0);
    run_until(4, 30, n);
    chk("saved_value", saved, 15);
    cycle(0, 1, 0);
    run_until(0, 20, n);
    chk("restored_value", result, 15);

    // wake during ISO_ON: one OFF cycle, then automatic wake
    cycle(1, 0, 0);
    run_until(3, 10, n);
    cycle(0, 1, 0);
    rc = 0; oc = 0; n = 0;
    while (seq_state !== 4'd0 && n < 30) begin
      cycle(0, 0, 0);
      if (restore === 1'b1) rc++;
      if (alu_off === 1'b1) oc++;
      n++;
    end
    chk("auto_wake_restores", rc, 1);
    chk("auto_wake_off_cycles", oc, 1);

    // reset during PWR_ON with a sleep pending
    cycle(1, 0, 0);
    run_until(4, 20, n);
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    chk("in_pwr_on", seq_state, 5);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    busy_cnt = 0;
    #2 rst_n = 1'b1;
    repeat (15) cycle(0, 0, 0);
    chk("no_auto_sleep", seq_state, 0);

    // simultaneous requests: sleep wins in ACTIVE, wake wins in OFF
    cycle(1, 1, 0);
    chk("both_in_active", seq_state, 1);
    run_until(4, 20, n);
    cycle(0, 0, 1);
    chk("start_gated_off", start_out, 0);
    cycle(1, 1, 0);
    chk("both_in_off", seq_state, 5);
    run_until(0, 20, n);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      bit s, w, st;
      s  = ($urandom_range(0, 11) == 0);
      w  = ($urandom_range(0, 11) == 0);
      st = (busy_cnt == 0) && ($urandom_range(0, 2) == 0);
      opa = $urandom_range(0, 15);
      opb = $urandom_range(0, 15);
      cycle(s, w, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
